// File: rtl/uop_sched_pkg.sv
// Shared microcode constants and types for the microop issue path.
package uop_sched_pkg;

  localparam int UOP_WIDTH     = 24;
  localparam int UOP_END_BIT   = 23;
  localparam int UCODE_ADDR_W  = 12;

  localparam logic [UOP_WIDTH-1:0] UOP_NOP = 24'h000000;

  typedef logic [UOP_WIDTH-1:0]    uop_t;
  typedef logic [UCODE_ADDR_W-1:0] ucode_addr_t;

endpackage

// File: rtl/uop_line_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with clear; head entry read combinationally.
module uop_line_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uop_issue_sched.sv
// Microop line scheduler: slot masking, empty-line drop, macroop tracking.
// Optional dispatch stall counter enabled by defining UOP_SCHED_STATS_EN.
module uop_issue_sched
  import uop_sched_pkg::*;
#(
  parameter int ISSUE_WIDTH = 4,
  parameter int DEPTH       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [UOP_WIDTH*ISSUE_WIDTH-1:0] in_line,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [UOP_WIDTH*ISSUE_WIDTH-1:0] out_uops,
  output logic [ISSUE_WIDTH-1:0]         out_mask,
  output logic                           out_last,
  output logic                           macro_done,
  output logic [15:0]                    stall_count
);

  localparam int LINE_W  = UOP_WIDTH * ISSUE_WIDTH;
  localparam int ENTRY_W = LINE_W + ISSUE_WIDTH + 1;

  logic [ISSUE_WIDTH-1:0] slot_mask;
  logic [ISSUE_WIDTH-1:0] slot_end;
  logic                   in_last;
  logic                   push_en, pop_en;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [ENTRY_W-1:0]     head_entry;
  logic                   macro_done_q, macro_done_d;

  genvar gi;
  generate
    for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
      assign slot_mask[gi] = (in_line[gi*UOP_WIDTH +: UOP_WIDTH] != UOP_NOP);
      assign slot_end[gi]  = slot_mask[gi] && in_line[gi*UOP_WIDTH + UOP_END_BIT];
    end
  endgenerate

  assign in_last   = |slot_end;
  assign in_ready  = !fifo_full && !flush;
  // All-NOP lines are handshaken but never occupy a FIFO entry.
  assign push_en   = in_valid && in_ready && (|slot_mask);
  assign out_valid = !fifo_empty;
  assign pop_en    = out_valid && out_ready;

  uop_line_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push_en),
    .push_data ({in_last, slot_mask, in_line}),
    .pop       (pop_en),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Gate head fields so uninitialised storage never reaches dispatch.
  assign out_uops = out_valid ? head_entry[LINE_W-1:0] : '0;
  assign out_mask = out_valid ? head_entry[LINE_W +: ISSUE_WIDTH] : '0;
  assign out_last = out_valid ? head_entry[ENTRY_W-1] : 1'b0;

  assign macro_done_d = pop_en && out_last && !flush;
  assign macro_done   = macro_done_q;

  always_ff @(posedge clk) begin
    if (rst) macro_done_q <= 1'b0;
    else     macro_done_q <= macro_done_d;
  end

`ifdef UOP_SCHED_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule
